// File: rtl/program_fetch_pkg.sv
// program_fetch_pkg: shared constants for the program fetch arbiter.
// Holds the FSM state encoding, requester count, fetch word width,
// byte-lane constants and a helper that assembles a fetch word from
// the four program memory byte lanes.
package program_fetch_pkg;

  localparam int unsigned NREQ    = 2;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned NLANES  = WORD_W / BYTE_W;
  localparam int unsigned STATE_W = 2;

  // Byte-lane index of each memory output inside the fetch word.
  localparam int unsigned LANE0 = 0;
  localparam int unsigned LANE1 = 1;
  localparam int unsigned LANE2 = 2;
  localparam int unsigned LANE3 = 3;

  localparam logic [STATE_W-1:0] ST_IDLE   = 2'd0;
  localparam logic [STATE_W-1:0] ST_SETTLE = 2'd1;
  localparam logic [STATE_W-1:0] ST_RESP   = 2'd2;

  // Lane 0 is the byte at the fetch address and lands in the LSBs.
  function automatic logic [WORD_W-1:0] pack_word(
    input logic [BYTE_W-1:0] b0,
    input logic [BYTE_W-1:0] b1,
    input logic [BYTE_W-1:0] b2,
    input logic [BYTE_W-1:0] b3
  );
    return {b3, b2, b1, b0};
  endfunction

endpackage

// File: rtl/program_fetch_rr_pick.sv
// program_fetch_rr_pick: two-way grant picker.
// Configuration macro: PROGRAM_FETCH_ARB_RR_EN
//   defined   -> round-robin; a pointer flips to the other requester after
//                every accepted grant and decides simultaneous conflicts.
//   undefined -> fixed priority, requester 0 wins; no pointer state exists.
// Ports:
//   clk, rst     clock and synchronous active-high reset (pointer only)
//   req          per-requester request vector
//   advance      a grant was accepted this cycle
//   grant_c      one-hot grant (combinational), zero when no request
//   grant_idx_c  index of the granted requester (combinational)
module program_fetch_rr_pick
  import program_fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            advance,
  output logic [NREQ-1:0] grant_c,
  output logic            grant_idx_c
);

`ifdef PROGRAM_FETCH_ARB_RR_EN
  // 0 favours requester 0 on a conflict, 1 favours requester 1.
  logic ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (advance) begin
      ptr <= ~grant_idx_c;
    end
  end

  always_comb begin
    grant_idx_c = 1'b0;
    case (req)
      2'b10:   grant_idx_c = 1'b1;
      2'b11:   grant_idx_c = ptr;
      default: grant_idx_c = 1'b0;
    endcase
  end
`else
  // Fixed priority needs no state; the clocking ports are intentionally idle.
  logic unused_ok;
  assign unused_ok = ^{clk, rst, advance};

  always_comb begin
    grant_idx_c = 1'b0;
    if (req == 2'b10) begin
      grant_idx_c = 1'b1;
    end
  end
`endif

  always_comb begin
    grant_c = '0;
    if (|req) begin
      grant_c[grant_idx_c] = 1'b1;
    end
  end

endmodule

// File: rtl/program_fetch_arbiter.sv
// program_fetch_arbiter: arbitrates two requesters onto one 4-byte-wide
// program memory. One fetch in flight at a time: IDLE accepts, SETTLE lets
// the memory output settle and captures it, RESP holds the word until the
// granted requester takes it.
// Configuration macro: PROGRAM_FETCH_ARB_RR_EN (round-robin when defined,
// fixed priority to requester 0 otherwise).
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid, req_addr0/1   fetch requests and byte addresses
//   req_ready                one-hot accept pulse (IDLE only)
//   rsp_valid, rsp_data      one-hot response valid and fetched word
//   rsp_ready                response consume, only granted bit matters
//   mem_address              program memory address
//   mem_out0..3              memory bytes at address+0..+3
//   busy                     high whenever not IDLE
module program_fetch_arbiter
  import program_fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  input  logic [ADDR_W-1:0] req_addr0,
  input  logic [ADDR_W-1:0] req_addr1,
  output logic [1:0]        req_ready,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [31:0]       rsp_data,
  output logic [ADDR_W-1:0] mem_address,
  input  logic [7:0]        mem_out0,
  input  logic [7:0]        mem_out1,
  input  logic [7:0]        mem_out2,
  input  logic [7:0]        mem_out3,
  output logic              busy
);

  logic [STATE_W-1:0] state;
  logic [STATE_W-1:0] state_nxt;
  logic               grant_q;
  logic [NREQ-1:0]    pick_grant_c;
  logic               pick_idx_c;
  logic               accept_c;
  logic               handshake_c;

  // Reset overrides any acceptance in the same cycle.
  assign accept_c    = (state == ST_IDLE) && (|req_valid) && !rst;
  assign handshake_c = (state == ST_RESP) && rsp_ready[grant_q];

  program_fetch_rr_pick u_pick (
    .clk         (clk),
    .rst         (rst),
    .req         (req_valid),
    .advance     (accept_c),
    .grant_c     (pick_grant_c),
    .grant_idx_c (pick_idx_c)
  );

  // Accept pulse is combinational so it lines up with the sampled request.
  assign req_ready = accept_c ? pick_grant_c : '0;
  assign busy      = (state != ST_IDLE);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (|req_valid) state_nxt = ST_SETTLE;
      ST_SETTLE: state_nxt = ST_RESP;
      ST_RESP:   if (handshake_c) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  // Datapath: address/grant capture, word capture, response valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_address <= '0;
      grant_q     <= 1'b0;
      rsp_data    <= '0;
      rsp_valid   <= '0;
    end else begin
      if (accept_c) begin
        mem_address <= pick_idx_c ? req_addr1 : req_addr0;
        grant_q     <= pick_idx_c;
      end
      if (state == ST_SETTLE) begin
        rsp_data  <= pack_word(mem_out0, mem_out1, mem_out2, mem_out3);
        rsp_valid <= grant_q ? 2'b10 : 2'b01;
      end else if (handshake_c) begin
        rsp_valid <= '0;
      end
    end
  end

endmodule

// File: doc/program_fetch_arbiter.md
PROGRAM_FETCH_ARBITER -- requirements
Module: program_fetch_arbiter

Interface
REQ-001 Parameter ADDR_W, default 8, memory byte-address width.
REQ-002 Parameter NREQ, fixed 2, number of requesters; not overridable.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  2  per-requester fetch request.
REQ-006 req_addr0, req_addr1  in  ADDR_W each  fetch byte address of requester 0/1.
REQ-007 req_ready  out  2  one-hot pulse; request accepted this cycle.
REQ-008 rsp_valid  out  2  one-hot; response data valid for that requester.
REQ-009 rsp_ready  in  2  requester consumes response.
REQ-010 rsp_data  out  32  {byte3,byte2,byte1,byte0} of fetched word.
REQ-011 mem_address  out  ADDR_W  drives the 4-byte program memory address input.
REQ-012 mem_out0..mem_out3  in  8 each  program memory bytes at address+0..+3.
REQ-013 busy  out  1  high whenever state is not IDLE.

Function
REQ-014 FSM states IDLE, SETTLE, RESP; encoding in shared package.
REQ-015 IDLE: if any req_valid, grant one requester, pulse its req_ready, register its address into mem_address, record grant index, go SETTLE.
REQ-016 IDLE with no req_valid: remain IDLE, mem_address holds last value.
REQ-017 SETTLE: capture {mem_out3,mem_out2,mem_out1,mem_out0} into rsp_data, go RESP; lasts exactly one cycle.
REQ-018 RESP: assert rsp_valid[grant] with stable rsp_data until rsp_ready[grant]; on handshake go IDLE same edge.
REQ-019 rsp_ready of the non-granted requester is ignored.
REQ-020 Latency: acceptance at cycle T, rsp_valid first high at T+2; minimum 3 cycles per transaction; no overlap.
REQ-021 req_ready only asserted in IDLE; requests in SETTLE/RESP wait (requester holds valid and address).
REQ-022 Address passed unmodified; +1..+3 wrap modulo 2^ADDR_W is performed by memory, arbiter does no arithmetic on it.
REQ-023 Arbitration on simultaneous req_valid per REQ-031.

Reset
REQ-024 On rst: state IDLE, req_ready=0, rsp_valid=0, rsp_data=0, mem_address=0, busy=0, priority pointer favours requester 0.
REQ-025 rst mid-transaction (SETTLE or RESP) discards in-flight fetch; no rsp_valid issued for it.
REQ-026 rst has priority over all handshakes in the same cycle.

Configuration
REQ-027 Macro PROGRAM_FETCH_ARB_RR_EN selects arbitration policy.
REQ-028 Defined: round-robin; after a grant, the other requester wins next simultaneous conflict.
REQ-029 Undefined: fixed priority, requester 0 always wins conflicts; priority pointer logic absent.
REQ-030 Single requester active: granted immediately under either policy.
REQ-031 Conflict winner determined in the IDLE accept cycle only.

Structure
REQ-032 Package program_fetch_pkg holds state enum, NREQ, WORD_W=32 and byte-lane constants.
REQ-033 Sub-module program_fetch_rr_pick (2-way grant picker with pointer) is natural; FSM and datapath stay in top.

Verification
REQ-034 Single fetch: req_valid=01, addr0=0x10, memory bytes 11,22,33,44 -> req_ready=01 at T, rsp_valid=01 at T+2, rsp_data=0x44332211.
REQ-035 Conflict, RR_EN defined: both valid continuously, rsp_ready tied high -> grants 0,1,0,1; undefined -> grants 0,0,0.
REQ-036 Backpressure: rsp_ready low 5 cycles -> rsp_valid and rsp_data held stable, no new req_ready until handshake.
REQ-037 Wrap: addr=0xFE, memory at FE,FF,00,01 = AA,BB,CC,DD -> mem_address=0xFE, rsp_data=0xDDCCBBAA.
REQ-038 Reset in RESP: rst one cycle -> next cycle rsp_valid=0, busy=0, outputs zero; pending request then re-granted from IDLE.
